// File: rtl/express_locker_ctrl_pkg.sv
// Shared types and defaults for the parcel-locker controller.
// State encoding, default parameter values and LFSR taps.
package express_locker_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ASSIGN   = 3'd1,
      SHOW     = 3'd2,
      RET_WAIT = 3'd3,
      CHECK    = 3'd4,
      LOCK     = 3'd5
   } state_t;

   localparam int unsigned DEF_N_BOXES   = 16;
   localparam int unsigned DEF_PWD_W     = 16;
   localparam int unsigned DEF_DEB       = 250000;
   localparam int unsigned DEF_TIMEOUT   = 500000000;
   localparam int unsigned DEF_TRIES     = 3;
   localparam int unsigned DEF_LOCK      = 1500000000;
   localparam logic [15:0] DEF_SEED      = 16'hACE1;

   // feedback taps q[15], q[13], q[12], q[10]
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] lfsr_next(input logic [15:0] q);
      return {q[14:0], ^(q & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/express_locker_ctrl_if.sv
// Board-side bundle: raw buttons and code switches in,
// box/display status out.
interface express_locker_ctrl_if #(
   parameter int unsigned N_BOXES = 16,
   parameter int unsigned PWD_W   = 16
);
   localparam int BOX_W = $clog2(N_BOXES);

   logic               check_bag;
   logic               make_sure;
   logic               get_bag;
   logic               to_input;
   logic [PWD_W-1:0]   user_password;
   logic [N_BOXES-1:0] box_led;
   logic [BOX_W:0]     free_count;
   logic [BOX_W-1:0]   show_box;
   logic [PWD_W-1:0]   show_pwd;
   logic               full;
   logic               open_pulse;
   logic [1:0]         err_cnt;
   logic               locked;
   logic [2:0]         state;

   modport master (
      output check_bag, make_sure, get_bag, to_input, user_password,
      input  box_led, free_count, show_box, show_pwd, full,
      input  open_pulse, err_cnt, locked, state
   );

   modport slave (
      input  check_bag, make_sure, get_bag, to_input, user_password,
      output box_led, free_count, show_box, show_pwd, full,
      output open_pulse, err_cnt, locked, state
   );
endinterface

// File: rtl/express_locker_ctrl_btn_pulse.sv
// Button conditioner: 2-FF sync, stable-high debounce,
// one pulse per press no matter how long it is held.
module express_locker_ctrl_btn_pulse #(
   parameter int unsigned DEB_CYCLES = 4
) (
   input  logic clk,
   input  logic restart,
   input  logic raw,
   output logic pulse
);
   localparam int CNT_W = $clog2(DEB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES);

   logic             s1;
   logic             s2;
   logic [CNT_W-1:0] cnt;

   // sync, count stable-high cycles, fire once when count saturates
   always_ff @(posedge clk or negedge restart) begin
      if (!restart) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         cnt   <= '0;
         pulse <= 1'b0;
      end else begin
         s1    <= raw;
         s2    <= s1;
         pulse <= s2 && (cnt == CNT_MAX - 1'b1);
         if (!s2)
            cnt <= '0;
         else if (cnt != CNT_MAX)
            cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/express_locker_ctrl.sv
// Parcel-locker controller: deposit to lowest free box with an
// LFSR pickup code, retrieve by code, lockout and timeouts.
module express_locker_ctrl
   import express_locker_ctrl_pkg::*;
#(
   parameter int unsigned N_BOXES        = DEF_N_BOXES,
   parameter int unsigned PWD_W          = DEF_PWD_W,
   parameter int unsigned DEB_CYCLES     = DEF_DEB,
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT,
   parameter int unsigned MAX_TRIES      = DEF_TRIES,
   parameter int unsigned LOCK_CYCLES    = DEF_LOCK,
   parameter logic [15:0] LFSR_SEED      = DEF_SEED
) (
   input  logic             clk,
   input  logic             restart,
   express_locker_ctrl_if.slave bus
);
   localparam int BOX_W = $clog2(N_BOXES);
   localparam logic [BOX_W:0] ALL_FREE  = (BOX_W+1)'(N_BOXES);
   localparam logic [31:0]    TO_LAST   = 32'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0]    LK_LAST   = 32'(LOCK_CYCLES - 1);
   localparam logic [1:0]     TRY_LAST  = 2'(MAX_TRIES - 1);

   logic check_p, make_p, get_p, input_p, any_p;

   express_locker_ctrl_btn_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_check (
      .clk(clk), .restart(restart), .raw(bus.check_bag), .pulse(check_p));
   express_locker_ctrl_btn_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_make (
      .clk(clk), .restart(restart), .raw(bus.make_sure), .pulse(make_p));
   express_locker_ctrl_btn_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_get (
      .clk(clk), .restart(restart), .raw(bus.get_bag), .pulse(get_p));
   express_locker_ctrl_btn_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_input (
      .clk(clk), .restart(restart), .raw(bus.to_input), .pulse(input_p));

   assign any_p = check_p | make_p | get_p | input_p;

   state_t             state_q, state_n;
   logic [15:0]        lfsr_q;
   logic [PWD_W-1:0]   codes [N_BOXES];
   logic [N_BOXES-1:0] occ_q;
   logic [BOX_W:0]     free_q;
   logic [BOX_W-1:0]   box_q;
   logic [PWD_W-1:0]   pwd_q;
   logic [PWD_W-1:0]   typed_q;
   logic [1:0]         err_q;
   logic [31:0]        tmr_q;
   logic               open_q;

   logic               latch, store, open, miss, lock_done, tmr_clr;
   logic               collide, match_any, timeout;
   logic [BOX_W-1:0]   free_idx, match_idx;

   // lowest free box, lowest matching box, code collision
   always_comb begin
      free_idx  = '0;
      match_idx = '0;
      match_any = 1'b0;
      collide   = 1'b0;
      for (int i = N_BOXES - 1; i >= 0; i--) begin
         if (!occ_q[i])
            free_idx = BOX_W'(i);
         if (occ_q[i] && codes[i] == typed_q && typed_q != '0) begin
            match_idx = BOX_W'(i);
            match_any = 1'b1;
         end
         if (occ_q[i] && codes[i] == lfsr_q)
            collide = 1'b1;
      end
   end

   assign timeout = (tmr_q == TO_LAST) && !any_p;

   // next state and datapath strobes
   always_comb begin
      state_n   = state_q;
      latch     = 1'b0;
      store     = 1'b0;
      open      = 1'b0;
      miss      = 1'b0;
      lock_done = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (get_p)
               state_n = RET_WAIT;
            else if (check_p && free_q != '0)
               state_n = ASSIGN;
         end
         ASSIGN: begin
            if (lfsr_q != '0 && !collide) begin
               latch   = 1'b1;
               state_n = SHOW;
            end
         end
         SHOW: begin
            if (make_p) begin
               store   = 1'b1;
               state_n = IDLE;
            end else if (timeout)
               state_n = IDLE;
         end
         RET_WAIT: begin
            if (input_p)
               state_n = CHECK;
            else if (timeout)
               state_n = IDLE;
         end
         CHECK: begin
            if (match_any) begin
               open    = 1'b1;
               state_n = IDLE;
            end else begin
               miss    = 1'b1;
               state_n = (err_q == TRY_LAST) ? LOCK : RET_WAIT;
            end
         end
         LOCK: begin
            if (tmr_q == LK_LAST) begin
               lock_done = 1'b1;
               state_n   = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
      // lockout ignores buttons, so they must not restart its timer
      tmr_clr = (state_n != state_q)
              || !(state_q inside {SHOW, RET_WAIT, LOCK})
              || (any_p && state_q != LOCK);
   end

   // state register, LFSR, code store and counters
   always_ff @(posedge clk or negedge restart) begin
      if (!restart) begin
         state_q <= IDLE;
         lfsr_q  <= LFSR_SEED;
         occ_q   <= '0;
         free_q  <= ALL_FREE;
         box_q   <= '0;
         pwd_q   <= '0;
         typed_q <= '0;
         err_q   <= '0;
         tmr_q   <= '0;
         open_q  <= 1'b0;
         for (int i = 0; i < N_BOXES; i++)
            codes[i] <= '0;
      end else begin
         state_q <= state_n;
         lfsr_q  <= lfsr_next(lfsr_q);
         open_q  <= open | store;
         tmr_q   <= tmr_clr ? '0 : tmr_q + 1'b1;
         if (latch) begin
            pwd_q <= lfsr_q;
            box_q <= free_idx;
         end
         if (store) begin
            codes[box_q] <= pwd_q;
            occ_q[box_q] <= 1'b1;
            free_q       <= free_q - 1'b1;
         end
         if (state_q == RET_WAIT && input_p)
            typed_q <= bus.user_password;
         if (open) begin
            codes[match_idx] <= '0;
            occ_q[match_idx] <= 1'b0;
            free_q           <= free_q + 1'b1;
            box_q            <= match_idx;
            err_q            <= '0;
         end
         if (miss)
            err_q <= err_q + 1'b1;
         if (lock_done)
            err_q <= '0;
      end
   end

   assign bus.box_led    = occ_q;
   assign bus.free_count = free_q;
   assign bus.show_box   = box_q;
   assign bus.show_pwd   = (state_q == SHOW) ? pwd_q : '0;
   assign bus.full       = (free_q == '0);
   assign bus.open_pulse = open_q;
   assign bus.err_cnt    = err_q;
   assign bus.locked     = (state_q == LOCK);
   assign bus.state      = state_q;
endmodule
